// File: rtl/rdma_sq_credit_ctrl_if.sv
// Handshake bundle for rdma_sq_credit_ctrl: user SQ in, SQ toward the crossing,
// acks from the crossing, completions to the user.
interface rdma_sq_credit_ctrl_if;
    logic         s_sq_valid;
    logic         s_sq_ready;
    logic [255:0] s_sq_data;
    logic         m_sq_valid;
    logic         m_sq_ready;
    logic [255:0] m_sq_data;
    logic         s_ack_valid;
    logic         s_ack_ready;
    logic [31:0]  s_ack_data;
    logic         m_cmpl_valid;
    logic         m_cmpl_ready;
    logic [31:0]  m_cmpl_data;

    modport slave (
        input  s_sq_valid, s_sq_data, m_sq_ready,
        input  s_ack_valid, s_ack_data, m_cmpl_ready,
        output s_sq_ready, m_sq_valid, m_sq_data,
        output s_ack_ready, m_cmpl_valid, m_cmpl_data
    );

    modport master (
        output s_sq_valid, s_sq_data, m_sq_ready,
        output s_ack_valid, s_ack_data, m_cmpl_ready,
        input  s_sq_ready, m_sq_valid, m_sq_data,
        input  s_ack_ready, m_cmpl_valid, m_cmpl_data
    );
endinterface

// File: rtl/rdma_sq_credit_ctrl.sv
// RDMA send-queue issuer with per-QP outstanding credit tracking and ack retirement.
// Optional nack-halt of a QP is enabled by defining RDMA_SQ_NACK_HALT_EN.
module rdma_sq_credit_ctrl #(
    parameter int N_QP_BITS       = 4,
    parameter int MAX_OUTSTANDING = 32,
    parameter int CNT_BITS        = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    rdma_sq_credit_ctrl_if.slave        bus,
    input  logic                        qp_clr_valid,
    input  logic [9:0]                  qp_clr_qpn,
    output logic [15:0]                 total_outstanding,
    output logic                        ack_underflow
);
    localparam int N_QP = 1 << N_QP_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(MAX_OUTSTANDING);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic [CNT_BITS-1:0]  r_cnt_r [N_QP];
    logic [N_QP-1:0]      r_halt_r;
    logic                 r_sq_valid_r;
    logic [255:0]         r_sq_data_r;
    logic                 r_cmpl_valid_r;
    logic [31:0]          r_cmpl_data_r;
    logic [15:0]          r_total_r;
    logic                 r_underflow_r;

    logic [N_QP_BITS-1:0] w_sq_qp_s;
    logic [N_QP_BITS-1:0] w_ack_qp_s;
    logic                 w_sq_ready_s;
    logic                 w_sq_acc_s;
    logic                 w_ack_ready_s;
    logic                 w_ack_acc_s;
    logic                 w_ack_zero_s;
    logic                 w_ack_dec_s;
    logic [N_QP-1:0]      w_inc_vec_s;
    logic [N_QP-1:0]      w_dec_vec_s;
    logic [CNT_BITS-1:0]  w_cnt_nxt_s [N_QP];
    logic [15:0]          w_total_nxt_s;
    logic [N_QP-1:0]      w_halt_nxt_s;

    assign w_sq_qp_s  = bus.s_sq_data[N_QP_BITS-1:0];
    assign w_ack_qp_s = bus.s_ack_data[N_QP_BITS-1:0];

    // Ready is gated by reset so nothing is taken while aresetn is low.
    assign w_sq_ready_s  = aresetn & (~r_sq_valid_r | bus.m_sq_ready)
                         & (r_cnt_r[w_sq_qp_s] < CNT_MAX) & ~r_halt_r[w_sq_qp_s];
    assign w_sq_acc_s    = bus.s_sq_valid & w_sq_ready_s;
    assign w_ack_ready_s = aresetn & (~r_cmpl_valid_r | bus.m_cmpl_ready);
    assign w_ack_acc_s   = bus.s_ack_valid & w_ack_ready_s;
    assign w_ack_zero_s  = (r_cnt_r[w_ack_qp_s] == CNT_ZERO);
    assign w_ack_dec_s   = w_ack_acc_s & ~w_ack_zero_s;

    // One-hot increment/decrement request per QP.
    always_comb begin
        w_inc_vec_s = {N_QP{1'b0}};
        w_dec_vec_s = {N_QP{1'b0}};
        if (w_sq_acc_s) begin
            w_inc_vec_s[w_sq_qp_s] = 1'b1;
        end else begin
            w_inc_vec_s = {N_QP{1'b0}};
        end
        if (w_ack_dec_s) begin
            w_dec_vec_s[w_ack_qp_s] = 1'b1;
        end else begin
            w_dec_vec_s = {N_QP{1'b0}};
        end
    end

    // Per-QP counter next state; inc and dec on one QP cancel.
    always_comb begin
        for (int i = 0; i < N_QP; i++) begin
            case ({w_inc_vec_s[i], w_dec_vec_s[i]})
                2'b10:   w_cnt_nxt_s[i] = r_cnt_r[i] + CNT_ONE;
                2'b01:   w_cnt_nxt_s[i] = r_cnt_r[i] - CNT_ONE;
                default: w_cnt_nxt_s[i] = r_cnt_r[i];
            endcase
        end
    end

    // Running total tracks the counter updates, so it equals their sum.
    always_comb begin
        case ({w_sq_acc_s, w_ack_dec_s})
            2'b10:   w_total_nxt_s = r_total_r + 16'd1;
            2'b01:   w_total_nxt_s = r_total_r - 16'd1;
            default: w_total_nxt_s = r_total_r;
        endcase
    end

`ifdef RDMA_SQ_NACK_HALT_EN
    logic                 w_nack_set_s;
    logic [N_QP_BITS-1:0] w_clr_qp_s;
    logic                 w_unused_s;

    assign w_nack_set_s = w_ack_acc_s & bus.s_ack_data[10];
    assign w_clr_qp_s   = qp_clr_qpn[N_QP_BITS-1:0];
    assign w_unused_s   = ^qp_clr_qpn[9:N_QP_BITS];

    // Halt next state: a nack on a QP outranks a same-cycle clear of it.
    always_comb begin
        w_halt_nxt_s = r_halt_r;
        for (int i = 0; i < N_QP; i++) begin
            if (w_nack_set_s && (w_ack_qp_s == N_QP_BITS'(i))) begin
                w_halt_nxt_s[i] = 1'b1;
            end else if (qp_clr_valid && (w_clr_qp_s == N_QP_BITS'(i))) begin
                w_halt_nxt_s[i] = 1'b0;
            end else begin
                w_halt_nxt_s[i] = r_halt_r[i];
            end
        end
    end
`else
    logic w_unused_s;

    assign w_unused_s = ^{qp_clr_valid, qp_clr_qpn};

    // Without the halt feature the halt bits never leave zero.
    always_comb begin
        w_halt_nxt_s = {N_QP{1'b0}};
    end
`endif

    // Credit state: counters, running total, halt bits, sticky underflow.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt_r       <= '{default: CNT_ZERO};
            r_total_r     <= 16'd0;
            r_halt_r      <= {N_QP{1'b0}};
            r_underflow_r <= 1'b0;
        end else begin
            r_cnt_r   <= w_cnt_nxt_s;
            r_total_r <= w_total_nxt_s;
            r_halt_r  <= w_halt_nxt_s;
            if (w_ack_acc_s && w_ack_zero_s) begin
                r_underflow_r <= 1'b1;
            end
        end
    end

    // SQ output register toward the crossing.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sq_valid_r <= 1'b0;
            r_sq_data_r  <= 256'd0;
        end else if (w_sq_acc_s) begin
            r_sq_valid_r <= 1'b1;
            r_sq_data_r  <= bus.s_sq_data;
        end else if (bus.m_sq_ready) begin
            r_sq_valid_r <= 1'b0;
        end
    end

    // Completion output register toward the user; underflowing acks still pass.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cmpl_valid_r <= 1'b0;
            r_cmpl_data_r  <= 32'd0;
        end else if (w_ack_acc_s) begin
            r_cmpl_valid_r <= 1'b1;
            r_cmpl_data_r  <= bus.s_ack_data;
        end else if (bus.m_cmpl_ready) begin
            r_cmpl_valid_r <= 1'b0;
        end
    end

    assign bus.s_sq_ready    = w_sq_ready_s;
    assign bus.m_sq_valid    = r_sq_valid_r;
    assign bus.m_sq_data     = r_sq_data_r;
    assign bus.s_ack_ready   = w_ack_ready_s;
    assign bus.m_cmpl_valid  = r_cmpl_valid_r;
    assign bus.m_cmpl_data   = r_cmpl_data_r;
    assign total_outstanding = r_total_r;
    assign ack_underflow     = r_underflow_r;
endmodule

// File: tb/tb_rdma_sq_credit_ctrl.sv
// Self-checking bench for rdma_sq_credit_ctrl: vector table, directed corner
// sequences and randomized traffic against a per-QP counting reference model.
module tb_rdma_sq_credit_ctrl;
    localparam int MAXO = 32;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        qp_clr_valid;
    logic [9:0]  qp_clr_qpn;
    logic [15:0] total_outstanding;
    logic        ack_underflow;

    rdma_sq_credit_ctrl_if bus ();

    rdma_sq_credit_ctrl #(
        .N_QP_BITS(4), .MAX_OUTSTANDING(MAXO), .CNT_BITS(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus),
        .qp_clr_valid(qp_clr_valid), .qp_clr_qpn(qp_clr_qpn),
        .total_outstanding(total_outstanding), .ack_underflow(ack_underflow)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int           m_cnt [16];
    bit           m_halt [16];
    bit           m_sqv, m_cv, m_uf;
    logic [255:0] m_sqd;
    logic [31:0]  m_cd;

    bit           last_sq_rdy, last_sq_acc, last_ack_rdy;
    logic [255:0] last_sd;
    logic [31:0]  last_ad;

    typedef struct {
        bit         sv;
        logic [9:0] sq_q;
        bit         av;
        logic [9:0] ack_q;
        bit         exp_sq_rdy;
        bit         exp_ack_rdy;
        int         exp_total;
        bit         exp_uf;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < 16; i++) s += m_cnt[i];
        return s;
    endfunction

    function automatic logic [255:0] mk_sq(input logic [9:0] q);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
        d[9:0] = q;
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_cnt[i]  = 0;
            m_halt[i] = 1'b0;
        end
        m_sqv = 1'b0; m_cv = 1'b0; m_uf = 1'b0;
        m_sqd = 256'd0; m_cd = 32'd0;
    endtask

    task automatic idle_inputs();
        bus.s_sq_valid = 1'b0; bus.s_sq_data = 256'd0; bus.m_sq_ready = 1'b0;
        bus.s_ack_valid = 1'b0; bus.s_ack_data = 32'd0; bus.m_cmpl_ready = 1'b0;
        qp_clr_valid = 1'b0; qp_clr_qpn = 10'd0;
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cyc(input bit sv, input logic [9:0] sq_q, input bit msr,
                       input bit av, input logic [9:0] ack_q, input bit nack,
                       input bit mcr, input bit clr, input logic [9:0] clr_q);
        logic [255:0] sd;
        logic [31:0]  ad;
        logic [20:0]  rsv;
        int q, a;
        bit esr, ear, sacc, aacc;
        sd  = mk_sq(sq_q);
        rsv = 21'($urandom());
        ad  = {rsv, nack, ack_q};
        bus.s_sq_valid = sv;  bus.s_sq_data = sd;  bus.m_sq_ready = msr;
        bus.s_ack_valid = av; bus.s_ack_data = ad; bus.m_cmpl_ready = mcr;
        qp_clr_valid = clr;   qp_clr_qpn = clr_q;
        last_sd = sd; last_ad = ad;
        #2;
        q   = int'(sq_q[3:0]);
        a   = int'(ack_q[3:0]);
        esr = (!m_sqv || msr) && (m_cnt[q] < MAXO) && !m_halt[q];
        ear = !m_cv || mcr;
        chk("s_sq_ready", bus.s_sq_ready, esr);
        chk("s_ack_ready", bus.s_ack_ready, ear);
        chk("m_sq_valid", bus.m_sq_valid, m_sqv);
        chk("m_sq_data", bus.m_sq_data, m_sqd);
        chk("m_cmpl_valid", bus.m_cmpl_valid, m_cv);
        chk("m_cmpl_data", bus.m_cmpl_data, m_cd);
        chk("total_outstanding", total_outstanding, 16'(m_total()));
        chk("ack_underflow", ack_underflow, m_uf);
        last_sq_rdy  = bus.s_sq_ready;
        last_ack_rdy = bus.s_ack_ready;
        last_sq_acc  = sv && bus.s_sq_ready;
        sacc = sv && esr;
        aacc = av && ear;
        if (aacc) begin
            if (m_cnt[a] == 0) m_uf = 1'b1;
            else m_cnt[a]--;
        end
        if (sacc) m_cnt[q]++;
`ifdef RDMA_SQ_NACK_HALT_EN
        if (clr) m_halt[clr_q[3:0]] = 1'b0;
        if (aacc && nack) m_halt[a] = 1'b1;
`endif
        if (sacc) begin m_sqv = 1'b1; m_sqd = sd; end
        else if (msr) m_sqv = 1'b0;
        if (aacc) begin m_cv = 1'b1; m_cd = ad; end
        else if (mcr) m_cv = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic sq(input logic [9:0] q);
        cyc(1'b1, q, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0);
    endtask

    task automatic ack(input logic [9:0] q, input bit nack);
        cyc(1'b0, 10'd0, 1'b1, 1'b1, q, nack, 1'b1, 1'b0, 10'd0);
    endtask

    initial begin
        int n_acc;
        bit gap;
        logic [255:0] d0;
        logic [31:0]  a0;

        aresetn = 1'b0;
        idle_inputs();
        model_reset();

        tbl[0] = '{1'b1, 10'd3,  1'b0, 10'd0, 1'b1, 1'b1, 1, 1'b0};
        tbl[1] = '{1'b1, 10'd3,  1'b0, 10'd0, 1'b1, 1'b1, 2, 1'b0};
        tbl[2] = '{1'b1, 10'd19, 1'b0, 10'd0, 1'b1, 1'b1, 3, 1'b0};
        tbl[3] = '{1'b1, 10'd3,  1'b1, 10'd3, 1'b1, 1'b1, 3, 1'b0};
        tbl[4] = '{1'b0, 10'd0,  1'b1, 10'd7, 1'b1, 1'b1, 3, 1'b1};
        tbl[5] = '{1'b0, 10'd0,  1'b1, 10'd3, 1'b1, 1'b1, 2, 1'b1};
        tbl[6] = '{1'b1, 10'd5,  1'b1, 10'd3, 1'b1, 1'b1, 2, 1'b1};
        tbl[7] = '{1'b1, 10'd21, 1'b1, 10'd5, 1'b1, 1'b1, 2, 1'b1};

        apply_reset();
        chk("reset_total", total_outstanding, 16'd0);
        chk("reset_underflow", ack_underflow, 1'b0);
        chk("reset_m_sq_valid", bus.m_sq_valid, 1'b0);
        chk("reset_m_cmpl_valid", bus.m_cmpl_valid, 1'b0);

        // vector table: aliasing, same/different-QP collisions, underflow
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].sv, tbl[i].sq_q, 1'b1, tbl[i].av, tbl[i].ack_q, 1'b0, 1'b1, 1'b0, 10'd0);
            chk("tbl_sq_ready", last_sq_rdy, tbl[i].exp_sq_rdy);
            chk("tbl_ack_ready", last_ack_rdy, tbl[i].exp_ack_rdy);
            chk("tbl_total", total_outstanding, 16'(tbl[i].exp_total));
            chk("tbl_underflow", ack_underflow, tbl[i].exp_uf);
            chk("tbl_m_sq_valid", bus.m_sq_valid, tbl[i].sv);
            chk("tbl_m_cmpl_valid", bus.m_cmpl_valid, tbl[i].av);
            if (tbl[i].sv) chk("tbl_m_sq_data", bus.m_sq_data, last_sd);
            if (tbl[i].av) chk("tbl_m_cmpl_data", bus.m_cmpl_data, last_ad);
        end

        // reset in the middle of traffic
        apply_reset();
        for (int i = 0; i < 5; i++) sq(10'd3);
        chk("mid_pre_total", total_outstanding, 16'd5);
        chk("mid_pre_sq_valid", bus.m_sq_valid, 1'b1);
        bus.s_sq_valid = 1'b1; bus.m_sq_ready = 1'b0; bus.s_ack_valid = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_sq_valid", bus.m_sq_valid, 1'b0);
        chk("mid_rst_cmpl_valid", bus.m_cmpl_valid, 1'b0);
        chk("mid_rst_total", total_outstanding, 16'd0);
        chk("mid_rst_sq_data", bus.m_sq_data, 256'd0);
        chk("mid_rst_sq_ready", bus.s_sq_ready, 1'b0);
        chk("mid_rst_ack_ready", bus.s_ack_ready, 1'b0);
        @(posedge aclk);
        #1;
        chk("mid_hold_sq_ready", bus.s_sq_ready, 1'b0);
        chk("mid_hold_ack_ready", bus.s_ack_ready, 1'b0);
        aresetn = 1'b1;
        model_reset();
        idle_inputs();

        // limit: 40 back-to-back on qpn 2
        apply_reset();
        n_acc = 0; gap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sq(10'd2);
            if (last_sq_acc) begin
                if (i != n_acc) gap = 1'b1;
                n_acc++;
            end
        end
        chk("limit_accepted", 32'(n_acc), 32'd32);
        chk("limit_consecutive", gap, 1'b0);
        chk("limit_ready_after", last_sq_rdy, 1'b0);
        chk("limit_total", total_outstanding, 16'd32);
        cyc(1'b1, 10'd2, 1'b1, 1'b1, 10'd2, 1'b0, 1'b1, 1'b0, 10'd0);
        chk("limit_same_cycle_blocked", last_sq_acc, 1'b0);
        sq(10'd2);
        chk("limit_next_cycle_accept", last_sq_acc, 1'b1);
        chk("limit_total_after", total_outstanding, 16'd32);

        // backpressure: both outputs stalled for 10 cycles
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 10'd6, 1'b0, 1'b1, 10'd6, 1'b0, 1'b0, 1'b0, 10'd0);
            if (i == 0) begin
                d0 = last_sd;
                a0 = last_ad;
            end
            chk("bp_sq_data", bus.m_sq_data, d0);
            chk("bp_cmpl_data", bus.m_cmpl_data, a0);
            chk("bp_total", total_outstanding, 16'd1);
        end

        // nack behaviour
        apply_reset();
        sq(10'd4);
        ack(10'd4, 1'b1);
`ifdef RDMA_SQ_NACK_HALT_EN
        sq(10'd4);
        chk("halt_blocks_q4", last_sq_acc, 1'b0);
        sq(10'd6);
        chk("halt_other_q6", last_sq_acc, 1'b1);
        cyc(1'b1, 10'd4, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 10'd4);
        chk("halt_clr_cycle", last_sq_acc, 1'b0);
        sq(10'd4);
        chk("halt_cleared", last_sq_acc, 1'b1);
        cyc(1'b0, 10'd0, 1'b1, 1'b1, 10'd4, 1'b1, 1'b1, 1'b1, 10'd4);
        sq(10'd4);
        chk("nack_beats_clr", last_sq_acc, 1'b0);
`else
        sq(10'd4);
        chk("nack_no_halt", last_sq_acc, 1'b1);
`endif

        // randomized traffic with alternating fill/drain phases
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            bit fill;
            fill = ((i / 600) % 2) == 0;
            cyc($urandom_range(0, 99) < 80, {6'($urandom()), 4'($urandom_range(0, 3))},
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 99) < (fill ? 20 : 85), {6'($urandom()), 4'($urandom_range(0, 3))},
                $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, {6'($urandom()), 4'($urandom_range(0, 3))});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
